calc1_port_responder: RTL and testbench
=======================================

CALC1_PORT_RESPONDER -- requirements
Module: calc1_port_responder

Interface
REQ-001 SHALL have parameter EXEC_CYCLES, default 1, the number of execute-stage cycles, legal range 1..8.
REQ-002 SHALL have port c_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port req_cmd_in, input, [0:3]: command nibble; 0 = no request.
REQ-005 SHALL have port req_data_in, input, [0:31]: operand 1 in the command cycle, operand 2 in the following cycle.
REQ-006 SHALL have port out_resp, output, [0:1]: 0 none, 1 success, 2 overflow/underflow, 3 invalid command.
REQ-007 SHALL have port out_data, output, [0:31]: result; valid only while out_resp != 0.
REQ-008 SHALL have port busy, output, 1 bit: high from the operand-2 cycle through the response cycle inclusive.
REQ-009 SHALL number all vectors big-endian: bit 0 is the MSB, bit 31 (bit 3 for commands) is the LSB.

Function
REQ-010 SHALL implement the FSM states IDLE, OP2, EXEC and RESP.
REQ-011 IDLE SHALL sample at each edge; when req_cmd_in != 0 it SHALL latch the command and operand 1 and go to OP2.
REQ-012 OP2 SHALL latch req_data_in as operand 2 unconditionally, load the EXEC counter with EXEC_CYCLES-1, and go to EXEC.
REQ-013 EXEC SHALL decrement the counter each cycle; at zero it SHALL register the result/response and go to RESP.
REQ-014 RESP SHALL drive the registered out_resp/out_data for exactly one cycle, then return to IDLE.
REQ-015 Latency SHALL be fixed: with command sampled at edge E0, the response SHALL be visible in the cycle following edge E(2+EXEC_CYCLES), and 0 everywhere else.
REQ-016 req_cmd_in SHALL be ignored in OP2, EXEC and RESP; a nonzero command is accepted again only in IDLE, so the earliest back-to-back accept is the edge ending the RESP cycle.
REQ-017 Command 1 (add) SHALL use a 33-bit sum; carry-out = 1 gives resp 2 and data 0, otherwise resp 1 and data = low 32 bits.
REQ-018 Command 2 (subtract) SHALL give resp 2 and data 0 when op2 > op1 unsigned, otherwise resp 1 and data = op1 - op2; op1 == op2 gives resp 1, data 0.
REQ-019 Command 5 (shift left) SHALL give resp 1 and data = op1 << op2[27:31], zero fill; bits shifted out are discarded and are not an error.
REQ-020 Command 6 (shift right) SHALL give resp 1 and data = op1 >> op2[27:31], logical zero fill; op2 bits [0:26] SHALL be ignored for commands 5 and 6.
REQ-021 Commands 3, 4 and 7..15 SHALL traverse the same FSM path and latency, then give resp 3 and data 0.
REQ-022 out_data SHALL be 0 whenever out_resp == 0.
REQ-023 All outputs SHALL be registered, with no combinational path from the inputs.

Reset
REQ-024 When reset is high at a rising edge, the state SHALL become IDLE, and out_resp, out_data and busy SHALL be 0 from the following cycle.
REQ-025 Reset asserted in any state SHALL abort the operation in flight; no response for it SHALL ever appear.
REQ-026 A command presented in the same cycle as reset SHALL be discarded.
REQ-027 The first accepted command after reset SHALL be one sampled in IDLE at an edge where reset is low.

Verification
REQ-028 Add check: cmd 1, op1 0000_0001h, op2 1FFF_FFFFh -> resp 1, data 2000_0000h, at exactly the REQ-015 cycle.
REQ-029 Add overflow check: cmd 1, op1 FFFF_FFFFh, op2 0000_0001h -> resp 2, data 0.
REQ-030 Subtract check: cmd 2, op1 0000_0001h, op2 0000_000Fh -> resp 2, data 0; then cmd 2, op1 Fh, op2 1h -> resp 1, data Eh.
REQ-031 Shift checks: cmd 5, op1 1h, op2 FFFF_FFE4h -> resp 1, data 10h; cmd 6, op1 8000_0000h, op2 1Fh -> resp 1, data 1h.
REQ-032 Invalid command checks: cmd 3, then cmd 4, then cmd 15, each with op 1 -> resp 3, data 0, with a one-cycle response pulse each.
REQ-033 Busy and reset checks: a nonzero cmd during EXEC is ignored (no extra response); reset high during EXEC -> no response, busy 0, and the next cmd 1 with 2h + 3h -> resp 1, data 5h.

Source files
------------

// File: rtl/calc1_port_responder.sv
// Two-operand command responder: accepts a command plus operand 1, takes operand 2 on the
// next cycle, runs a fixed-length execute phase and returns a one-cycle registered response.
module calc1_port_responder #(
   parameter int EXEC_CYCLES = 1
) (
   input  logic        c_clk,
   input  logic        reset,
   input  logic [0:3]  req_cmd_in,
   input  logic [0:31] req_data_in,
   output logic [0:1]  out_resp,
   output logic [0:31] out_data,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, OP2, EXEC, RESP} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [2:0]  r_cnt;
   logic [0:3]  r_cmd;
   logic [0:31] r_op1;
   logic [0:31] r_op2;
   logic [0:1]  r_res_resp;
   logic [0:31] r_res_data;
   logic [0:1]  r_out_resp;
   logic [0:31] r_out_data;
   logic        r_busy;

   logic [32:0] w_sum;
   logic [4:0]  w_shamt;
   logic [0:1]  w_resp;
   logic [0:31] w_data;

   always_ff @(posedge c_clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Commands are only looked at in IDLE; every other state advances unconditionally.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (req_cmd_in != 4'd0) w_next = OP2;
         OP2:     w_next = EXEC;
         EXEC:    if (r_cnt == 3'd0) w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_sum   = {1'b0, r_op1} + {1'b0, r_op2};
      w_shamt = r_op2[27:31];
      w_resp  = 2'd3;
      w_data  = 32'd0;
      case (r_cmd)
         4'd1: begin
            if (w_sum[32]) w_resp = 2'd2;
            else begin
               w_resp = 2'd1;
               w_data = w_sum[31:0];
            end
         end
         4'd2: begin
            if (r_op2 > r_op1) w_resp = 2'd2;
            else begin
               w_resp = 2'd1;
               w_data = r_op1 - r_op2;
            end
         end
         4'd5: begin
            w_resp = 2'd1;
            w_data = r_op1 << w_shamt;
         end
         4'd6: begin
            w_resp = 2'd1;
            w_data = r_op1 >> w_shamt;
         end
         default: begin
            w_resp = 2'd3;
            w_data = 32'd0;
         end
      endcase
   end

   // Outputs lag the RESP state by one edge so that nothing reaches a port combinationally.
   always_ff @(posedge c_clk) begin
      if (reset) begin
         r_cnt      <= 3'd0;
         r_cmd      <= 4'd0;
         r_op1      <= 32'd0;
         r_op2      <= 32'd0;
         r_res_resp <= 2'd0;
         r_res_data <= 32'd0;
         r_out_resp <= 2'd0;
         r_out_data <= 32'd0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_cmd_in != 4'd0) begin
                  r_cmd <= req_cmd_in;
                  r_op1 <= req_data_in;
               end
            end
            OP2: begin
               r_op2 <= req_data_in;
               r_cnt <= 3'(EXEC_CYCLES - 1);
            end
            EXEC: begin
               if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
               else begin
                  r_res_resp <= w_resp;
                  r_res_data <= w_data;
               end
            end
            default: ;
         endcase
         if (r_state == RESP) begin
            r_out_resp <= r_res_resp;
            r_out_data <= r_res_data;
         end else begin
            r_out_resp <= 2'd0;
            r_out_data <= 32'd0;
         end
         r_busy <= (w_next != IDLE) || (r_state == RESP);
      end
   end

   assign out_resp = r_out_resp;
   assign out_data = r_out_data;
   assign busy     = r_busy;

endmodule

// File: tb/tb_calc1_port_responder.sv
// Directed bench for calc1_port_responder: fixed-latency response window, arithmetic
// corner cases, ignored commands while busy, and reset abort.
module tb_calc1_port_responder;

  localparam int N = 1;

  logic        c_clk;
  logic        reset;
  logic [0:3]  req_cmd_in;
  logic [0:31] req_data_in;
  logic [0:1]  out_resp;
  logic [0:31] out_data;
  logic        busy;

  int n_total;
  int n_bad;

  calc1_port_responder #(.EXEC_CYCLES(N)) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .out_resp    (out_resp),
    .out_data    (out_data),
    .busy        (busy)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge after the window has closed.
  // With poke set, a nonzero command is held through OP2/EXEC and must be ignored.
  task automatic do_op(input string name, input logic [3:0] cmd, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] er, input logic [31:0] ed,
                       input bit poke);
    req_cmd_in  = cmd;
    req_data_in = a;
    @(posedge c_clk);
    @(negedge c_clk);
    req_data_in = b;
    req_cmd_in  = poke ? 4'h9 : 4'h0;
    chk({name, " op2 busy"}, 32'(busy), 32'd1);
    chk({name, " op2 resp"}, 32'(out_resp), 32'd0);
    for (int k = 1; k <= 3 + N; k++) begin
      @(posedge c_clk);
      @(negedge c_clk);
      req_data_in = $urandom;
      req_cmd_in  = (poke && k < 1 + N) ? 4'h9 : 4'h0;
      chk($sformatf("%s k%0d resp", name, k), 32'(out_resp), (k == 2 + N) ? 32'(er) : 32'd0);
      chk($sformatf("%s k%0d data", name, k), out_data, (k == 2 + N) ? ed : 32'd0);
      chk($sformatf("%s k%0d busy", name, k), 32'(busy), (k <= 2 + N) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    n_total     = 0;
    n_bad       = 0;
    reset       = 1'b1;
    req_cmd_in  = 4'h0;
    req_data_in = 32'h0;
    repeat (3) @(posedge c_clk);
    @(negedge c_clk);
    chk("reset resp", 32'(out_resp), 32'd0);
    chk("reset data", out_data, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge c_clk);

    do_op("add",      4'd1,  32'h0000_0001, 32'h1FFF_FFFF, 2'd1, 32'h2000_0000, 1'b0);
    do_op("add_ovf",  4'd1,  32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0,         1'b0);
    do_op("add_max",  4'd1,  32'h7FFF_FFFF, 32'h8000_0000, 2'd1, 32'hFFFF_FFFF, 1'b0);
    do_op("sub_unf",  4'd2,  32'h0000_0001, 32'h0000_000F, 2'd2, 32'h0,         1'b0);
    do_op("sub",      4'd2,  32'h0000_000F, 32'h0000_0001, 2'd1, 32'h0000_000E, 1'b0);
    do_op("sub_eq",   4'd2,  32'h0000_0005, 32'h0000_0005, 2'd1, 32'h0,         1'b0);
    do_op("shl",      4'd5,  32'h0000_0001, 32'hFFFF_FFE4, 2'd1, 32'h0000_0010, 1'b0);
    do_op("shl_out",  4'd5,  32'h0000_0003, 32'h0000_001F, 2'd1, 32'h8000_0000, 1'b0);
    do_op("shr",      4'd6,  32'h8000_0000, 32'h0000_001F, 2'd1, 32'h0000_0001, 1'b0);
    do_op("inv3",     4'd3,  32'h0000_0001, 32'h0000_0001, 2'd3, 32'h0,         1'b0);
    do_op("inv4",     4'd4,  32'h0000_0001, 32'h0000_0001, 2'd3, 32'h0,         1'b0);
    do_op("inv15",    4'd15, 32'h0000_0001, 32'h0000_0001, 2'd3, 32'h0,         1'b0);
    do_op("busy_cmd", 4'd1,  32'h0000_0010, 32'h0000_0020, 2'd1, 32'h0000_0030, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge c_clk);
      @(negedge c_clk);
      chk($sformatf("no_extra %0d resp", i), 32'(out_resp), 32'd0);
      chk($sformatf("no_extra %0d busy", i), 32'(busy), 32'd0);
    end

    // Abort during EXEC; the command presented alongside reset must be dropped too.
    req_cmd_in  = 4'd1;
    req_data_in = 32'h0000_0007;
    @(posedge c_clk);
    @(negedge c_clk);
    req_cmd_in  = 4'd0;
    req_data_in = 32'h0000_0008;
    @(posedge c_clk);
    @(negedge c_clk);
    reset       = 1'b1;
    req_cmd_in  = 4'd1;
    req_data_in = 32'h0000_0009;
    @(posedge c_clk);
    @(negedge c_clk);
    reset      = 1'b0;
    req_cmd_in = 4'd0;
    chk("abort resp", 32'(out_resp), 32'd0);
    chk("abort data", out_data, 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge c_clk);
      @(negedge c_clk);
      chk($sformatf("post_abort %0d resp", i), 32'(out_resp), 32'd0);
      chk($sformatf("post_abort %0d busy", i), 32'(busy), 32'd0);
    end
    do_op("after_rst", 4'd1, 32'h0000_0002, 32'h0000_0003, 2'd1, 32'h0000_0005, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
